dmp_pmp_csr: RTL and testbench
==============================

# dmp_pmp_csr

Register file and write path for the PMP and JITDomain (DMP) configuration consumed by the combinational PMP checker. Accepts M-mode CSR read/write requests over a valid/ready handshake, applies WARL legalization and lock rules, and holds the `pmpcfg`, `pmpaddr` and `dmpcfg` state. It drives the checker's configuration inputs from registers and pulses a flush strobe to the MMU and TLBs whenever the stored configuration changes.

## Interface
- `PMP_LEN`, default 54: stored width of each `pmpaddr` entry.
- `NR_ENTRIES`, default 16: implemented entries (0..16). Higher entries are hardwired to zero.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset: synchronous, active-low. One clock; all state is updated on the rising edge of `clk_i`.
- `req_valid_i`  in  1  CSR request valid.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  12  CSR address.
- `req_wdata_i`  in  64  write data.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_rdata_o`  out  64  read data. For writes, this is the post-write value.
- `rsp_err_o`  out  1  illegal CSR address.
- `conf_addr_o`  out  16×PMP_LEN  `pmpaddr` entries.
- `pmpconf_o`  out  16×`riscv::pmpcfg_t`  `pmpcfg` entries.
- `dmpconf_o`  out  16×`riscv::dmpcfg_t`  `dmpcfg` entries.
- `cfg_update_o`  out  1  one-cycle pulse when any stored bit changed.

## Operation
- CSR map (RV64):
  - `pmpcfg0` 0x3A0 holds entries 0–7; `pmpcfg2` 0x3A2 holds entries 8–15.
  - `pmpaddr0..15` 0x3B0–0x3BF.
  - `dmpcfg0` 0x7C0 holds entries 0–7; `dmpcfg2` 0x7C2 holds entries 8–15.
  - Byte i of a cfg word belongs to entry i (or entry 8+i for the `*2` registers).
  - Any other address, including 0x3A1, 0x3A3, 0x7C1 and 0x7C3: `rsp_err_o`=1, no state change, `rsp_rdata_o`=0.
- `pmpcfg` byte layout: [7] L, [6:5] zero, [4:3] A, [2] X, [1] W, [0] R.
- `dmpcfg` byte layout: [7] L, [6:4] zero, [3:0] `riscv::dmp_domain_t` domain.
- Reserved bits always read zero.
- Legalization:
  - A `pmpcfg` byte with R=0, W=1 is stored with W=0.
  - `pmpaddr` keeps `wdata[PMP_LEN-1:0]`; upper bits read zero.
- Lock rules. A blocked field keeps its old value; other bytes in the same word still update.
  - `pmpcfg` byte i is ignored if `pmpcfg[i].L`=1.
  - `pmpaddr[i]` is ignored if `pmpcfg[i].L`=1, or if `pmpcfg[i+1].L`=1 and `pmpcfg[i+1].A`=TOR.
  - `dmpcfg` byte i is ignored if `dmpcfg[i].L`=1.
  - L bits are sticky until reset.
- Lock checks use the state before the write. A write that sets L also applies its own R/W/X/A fields in the same write.
- Entries with index ≥ NR_ENTRIES read zero, ignore writes, and drive zero on the outputs.
- FSM:
  - IDLE: `req_ready_o`=1. On `req_valid_i`, perform the access (read, or write plus readback) and go to RESP.
  - RESP: `req_ready_o`=0, `rsp_valid_o`=1. Outputs stay stable until `rsp_ready_i`=1, then return to IDLE.
  - There is no bypass: back-to-back requests run at most one every 2 cycles.
- `cfg_update_o` = 1 in the cycle after the accepting edge if and only if a write changed at least one stored bit. It is 0 for reads, errors, fully blocked writes and identical-value writes.

## Timing
- Reset values:
  - `req_ready_o`=1; `rsp_valid_o`=0; `rsp_rdata_o`=0; `rsp_err_o`=0; `cfg_update_o`=0.
  - All `pmpaddr`=0.
  - All `pmpcfg`=0 (A=OFF, unlocked).
  - All `dmpcfg` unlocked, domain=DOMI.
- Write accepted at edge N:
  - `conf_addr_o`, `pmpconf_o` and `dmpconf_o` show the new value after edge N.
  - `rsp_valid_o` and `cfg_update_o` are high in cycle N+1.
- Response latency: 1 cycle after acceptance. It holds for as long as `rsp_ready_i` stays low.
- Reset asserted in RESP: the response is dropped, state returns to IDLE, and all configuration returns to reset values, including L bits.
- Configuration outputs come straight from flops, with no combinational path from the request ports.

## Test plan
- Reset, then read 0x3A0 → `rsp_rdata_o`=0, `rsp_err_o`=0, `req_ready_o`=1 after reset.
- Write 0x3A0 = 0x0000_0000_0000_0F02 → stored byte0=0x00 (R=0, W=1 is illegal, so W is cleared); byte1=0x0F; `cfg_update_o` pulses; readback = 0x0F00.
- Lock `pmpcfg` entry 1 as TOR (byte1=0x8F), then write `pmpaddr0` and `pmpaddr1` with 0x1234 → both unchanged, no `cfg_update_o`. A write to `pmpaddr2` updates.
- Write 0x7C0 = 0x85 (locked, domain 5), then 0x7C0 = 0x03 → byte0 stays 0x85; `dmpconf_o[0].domain`=5.
- Access 0x3A1 (write) and 0x7C3 (read) → `rsp_err_o`=1, `rsp_rdata_o`=0, no state change.
- Hold `rsp_ready_i`=0 for 5 cycles while `req_valid_i`=1 → `rsp_valid_o` is held, `req_ready_o`=0, and the second request is accepted only on the first IDLE cycle. Assert `rst_ni`=0 during RESP → `rsp_valid_o`=0 and all configuration is cleared next cycle.

Source files
------------

// File: rtl/dmp_pmp_csr.sv
// PMP / DMP configuration register file with a valid/ready CSR write path.
// Each cfg byte uses the riscv::pmpcfg_t / riscv::dmpcfg_t packed layout.
module dmp_pmp_csr #(
   parameter int unsigned PMP_LEN    = 54,
   parameter int unsigned NR_ENTRIES = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic                           req_we_i,
   input  logic [11:0]                    req_addr_i,
   input  logic [63:0]                    req_wdata_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [63:0]                    rsp_rdata_o,
   output logic                           rsp_err_o,
   output logic [15:0][PMP_LEN-1:0]       conf_addr_o,
   output logic [15:0][7:0]               pmpconf_o,
   output logic [15:0][7:0]               dmpconf_o,
   output logic                           cfg_update_o
);

   typedef enum logic {IDLE, RESP} state_e;

   state_e                   state_q, state_d;
   logic [15:0][7:0]         pmpcfg_q, pmpcfg_d;
   logic [15:0][7:0]         dmpcfg_q, dmpcfg_d;
   logic [15:0][PMP_LEN-1:0] pmpaddr_q, pmpaddr_d;
   logic [63:0]              rdata_q, rdata_d;
   logic                     err_q, err_d, upd_q, upd_d;
   logic                     accept;
   logic [15:0]              impl;
   logic [7:0][7:0]          wbytes, rbytes;
   logic [7:0]               b;
   logic [3:0]               e, nxt;
   logic                     locked;

   assign accept = (state_q == IDLE) && req_valid_i;
   assign wbytes = req_wdata_i;

   always_comb begin
      for (int unsigned k = 0; k < 16; k++) impl[k] = (k < NR_ENTRIES);
   end

   always_comb begin
      state_d   = state_q;
      pmpcfg_d  = pmpcfg_q;
      dmpcfg_d  = dmpcfg_q;
      pmpaddr_d = pmpaddr_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      upd_d     = 1'b0;
      rbytes    = '0;
      b         = '0;
      e         = '0;
      nxt       = '0;
      locked    = 1'b0;

      case (state_q)
         IDLE: if (req_valid_i) state_d = RESP;
         RESP: if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         rdata_d = '0;
         err_d   = 1'b0;
         if (req_addr_i == 12'h3A0 || req_addr_i == 12'h3A2) begin
            for (int unsigned i = 0; i < 8; i++) begin
               e = {req_addr_i[1], i[2:0]};
               b = wbytes[i[2:0]];
               // W is only kept when R is set; reserved bits [6:5] forced low
               if (req_we_i && impl[e] && !pmpcfg_q[e][7])
                  pmpcfg_d[e] = {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
               rbytes[i[2:0]] = pmpcfg_d[e];
            end
            rdata_d = rbytes;
         end else if (req_addr_i[11:4] == 8'h3B) begin
            e      = req_addr_i[3:0];
            nxt    = e + 4'd1;
            // a locked TOR entry above also freezes this entry's address
            locked = pmpcfg_q[e][7] ||
                     ((e != 4'hF) && pmpcfg_q[nxt][7] && (pmpcfg_q[nxt][4:3] == 2'b01));
            if (req_we_i && impl[e] && !locked)
               pmpaddr_d[e] = req_wdata_i[PMP_LEN-1:0];
            rdata_d[PMP_LEN-1:0] = pmpaddr_d[e];
         end else if (req_addr_i == 12'h7C0 || req_addr_i == 12'h7C2) begin
            for (int unsigned i = 0; i < 8; i++) begin
               e = {req_addr_i[1], i[2:0]};
               b = wbytes[i[2:0]];
               if (req_we_i && impl[e] && !dmpcfg_q[e][7])
                  dmpcfg_d[e] = {b[7], 3'b000, b[3:0]};
               rbytes[i[2:0]] = dmpcfg_d[e];
            end
            rdata_d = rbytes;
         end else begin
            err_d = 1'b1;
         end
         upd_d = (pmpcfg_d != pmpcfg_q) || (dmpcfg_d != dmpcfg_q) || (pmpaddr_d != pmpaddr_q);
      end
   end

   // Domain encoding DOMI is zero, so a cleared dmpcfg is its reset value.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         pmpcfg_q  <= '0;
         dmpcfg_q  <= '0;
         pmpaddr_q <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         upd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pmpcfg_q  <= pmpcfg_d;
         dmpcfg_q  <= dmpcfg_d;
         pmpaddr_q <= pmpaddr_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         upd_q     <= upd_d;
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign rsp_valid_o  = (state_q == RESP);
   assign rsp_rdata_o  = rdata_q;
   assign rsp_err_o    = err_q;
   assign cfg_update_o = upd_q;
   assign conf_addr_o  = pmpaddr_q;
   assign pmpconf_o    = pmpcfg_q;
   assign dmpconf_o    = dmpcfg_q;

endmodule

// File: tb/tb_dmp_pmp_csr.sv
// Randomized bench for dmp_pmp_csr against an array-based reference model.
module tb_dmp_pmp_csr;

   localparam int unsigned PL = 54;
   localparam int unsigned NR = 12;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic                 req_we = 1'b0;
   logic [11:0]          req_addr = '0;
   logic [63:0]          req_wdata = '0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b0;
   logic [63:0]          rsp_rdata;
   logic                 rsp_err;
   logic [15:0][PL-1:0]  conf_addr;
   logic [15:0][7:0]     pmpconf;
   logic [15:0][7:0]     dmpconf;
   logic                 cfg_update;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [7:0]  m_cfg [16];
   logic [7:0]  m_dmp [16];
   logic [63:0] m_addr[16];

   always #5 clk = ~clk;

   dmp_pmp_csr #(.PMP_LEN(PL), .NR_ENTRIES(NR)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .conf_addr_o(conf_addr), .pmpconf_o(pmpconf),
      .dmpconf_o(dmpconf), .cfg_update_o(cfg_update)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_cfg[i] = '0; m_dmp[i] = '0; m_addr[i] = '0;
      end
   endtask

   task automatic model_access(input logic we, input logic [11:0] a, input logic [63:0] wd,
                               output logic [63:0] rd, output logic err, output logic chg);
      logic [7:0]  oc[16];
      logic [7:0]  od[16];
      logic [63:0] oa[16];
      logic [7:0]  v;
      int          base, ent;
      bit          lk;
      oc = m_cfg; od = m_dmp; oa = m_addr;
      rd = '0; err = 1'b0; chg = 1'b0;
      if (a == 12'h3A0 || a == 12'h3A2) begin
         base = (a == 12'h3A2) ? 8 : 0;
         for (int i = 0; i < 8; i++) begin
            ent = base + i;
            v = wd[8*i +: 8] & 8'h9F;
            if (v[0] == 1'b0) v[1] = 1'b0;
            if (we && ent < NR && !oc[ent][7]) m_cfg[ent] = v;
            rd[8*i +: 8] = m_cfg[ent];
         end
      end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
         ent = int'(a) - 'h3B0;
         lk = oc[ent][7];
         if (ent < 15 && oc[ent+1][7] && oc[ent+1][4:3] == 2'd1) lk = 1'b1;
         if (we && ent < NR && !lk) m_addr[ent] = wd & ((64'd1 << PL) - 64'd1);
         rd = m_addr[ent];
      end else if (a == 12'h7C0 || a == 12'h7C2) begin
         base = (a == 12'h7C2) ? 8 : 0;
         for (int i = 0; i < 8; i++) begin
            ent = base + i;
            if (we && ent < NR && !od[ent][7]) m_dmp[ent] = wd[8*i +: 8] & 8'h8F;
            rd[8*i +: 8] = m_dmp[ent];
         end
      end else begin
         err = 1'b1;
      end
      for (int i = 0; i < 16; i++)
         if (oc[i] != m_cfg[i] || od[i] != m_dmp[i] || oa[i] != m_addr[i]) chg = 1'b1;
   endtask

   task automatic check_conf(input string tag);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("%s_pmpaddr%0d", tag, i), 64'(conf_addr[i]), m_addr[i]);
         check($sformatf("%s_pmpcfg%0d", tag, i), 64'(pmpconf[i]), 64'(m_cfg[i]));
         check($sformatf("%s_dmpcfg%0d", tag, i), 64'(dmpconf[i]), 64'(m_dmp[i]));
      end
   endtask

   task automatic do_req(input logic we, input logic [11:0] a, input logic [63:0] wd,
                         output logic [63:0] rd, output logic err, output logic upd);
      logic [63:0] erd;
      logic        eerr, echg;
      int          w;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      model_access(we, a, wd, erd, eerr, echg);
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("req_ready_resp", 64'(req_ready), 64'd0);
      check($sformatf("rdata@%h", a), rsp_rdata, erd);
      check($sformatf("err@%h", a), 64'(rsp_err), 64'(eerr));
      check($sformatf("cfg_update@%h", a), 64'(cfg_update), 64'(echg));
      check_conf("txn");
      rd = rsp_rdata; err = rsp_err; upd = cfg_update;
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
      check("cfg_update_pulse", 64'(cfg_update), 64'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      @(posedge clk); #1;
      model_reset();
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_valid", 64'(rsp_valid), 64'd0);
      check("rst_rdata", rsp_rdata, 64'd0);
      check("rst_err", 64'(rsp_err), 64'd0);
      check("rst_upd", 64'(cfg_update), 64'd0);
      check_conf("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] rd, erd, wd;
      logic        err, upd, eerr, echg;
      logic [11:0] a, bad_addrs[6];
      int          r;
      bad_addrs[0] = 12'h3A1; bad_addrs[1] = 12'h3A3; bad_addrs[2] = 12'h7C1;
      bad_addrs[3] = 12'h7C3; bad_addrs[4] = 12'h000; bad_addrs[5] = 12'h3C0;
      model_reset();
      repeat (2) @(posedge clk);
      apply_reset();

      do_req(1'b0, 12'h3A0, 64'd0, rd, err, upd);
      check("first_read", rd, 64'd0);
      check("first_read_err", 64'(err), 64'd0);

      do_req(1'b1, 12'h3A0, 64'h0F02, rd, err, upd);
      check("wlegal_rb", rd, 64'h0F00);
      check("wlegal_upd", 64'(upd), 64'd1);

      do_req(1'b1, 12'h3A0, 64'h8F00, rd, err, upd);
      check("tor_lock_upd", 64'(upd), 64'd1);
      do_req(1'b1, 12'h3B0, 64'h1234, rd, err, upd);
      check("addr0_blocked", rd, 64'd0);
      check("addr0_noupd", 64'(upd), 64'd0);
      do_req(1'b1, 12'h3B1, 64'h1234, rd, err, upd);
      check("addr1_blocked", rd, 64'd0);
      check("addr1_noupd", 64'(upd), 64'd0);
      do_req(1'b1, 12'h3B2, 64'h1234, rd, err, upd);
      check("addr2_written", rd, 64'h1234);
      check("addr2_upd", 64'(upd), 64'd1);
      do_req(1'b1, 12'h3A0, 64'h0000, rd, err, upd);
      check("cfg1_sticky", rd, 64'h8F00);

      do_req(1'b1, 12'h7C0, 64'h85, rd, err, upd);
      do_req(1'b1, 12'h7C0, 64'h03, rd, err, upd);
      check("dmp_locked_rb", rd, 64'h85);
      check("dmp0_domain", 64'(dmpconf[0][3:0]), 64'd5);

      do_req(1'b1, 12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF, rd, err, upd);
      check("err_3a1", 64'(err), 64'd1);
      check("err_3a1_rdata", rd, 64'd0);
      do_req(1'b0, 12'h7C3, 64'd0, rd, err, upd);
      check("err_7c3", 64'(err), 64'd1);

      do_req(1'b1, 12'h3BF, 64'hFFFF_FFFF_FFFF_FFFF, rd, err, upd);
      check("unimpl_addr15", rd, 64'd0);
      do_req(1'b1, 12'h3A2, 64'h0F0F_0F0F_0F0F_0F0F, rd, err, upd);
      check("unimpl_cfg_hi", rd, 64'h0000_0000_0F0F_0F0F);

      // backpressure: second request held off until the RESP state clears
      @(negedge clk);
      wd = {$urandom, $urandom};
      req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h3B3; req_wdata = wd;
      @(posedge clk); #1;
      model_access(1'b1, 12'h3B3, wd, erd, eerr, echg);
      check("bp_first_rdata", rsp_rdata, erd);
      @(negedge clk);
      req_we = 1'b0; req_addr = 12'h3B3;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", 64'(rsp_valid), 64'd1);
         check("bp_hold_ready", 64'(req_ready), 64'd0);
         check("bp_hold_rdata", rsp_rdata, erd);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle_ready", 64'(req_ready), 64'd1);
      check("bp_idle_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      model_access(1'b0, 12'h3B3, 64'd0, erd, eerr, echg);
      check("bp_second_valid", 64'(rsp_valid), 64'd1);
      check("bp_second_rdata", rsp_rdata, erd);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // reset while a response is pending
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h7C2; req_wdata = 64'h8181;
      @(posedge clk); #1;
      req_valid = 1'b0;
      model_access(1'b1, 12'h7C2, 64'h8181, erd, eerr, echg);
      check("rr_valid", 64'(rsp_valid), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      model_reset();
      check("rr_drop_valid", 64'(rsp_valid), 64'd0);
      check("rr_ready", 64'(req_ready), 64'd1);
      check_conf("rr");
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 300; n++) begin
         if (n % 60 == 59) apply_reset();
         r = $urandom_range(0, 9);
         if (r < 2)      a = ($urandom_range(0, 1) != 0) ? 12'h3A2 : 12'h3A0;
         else if (r < 6) a = 12'h3B0 | 12'($urandom_range(0, 15));
         else if (r < 8) a = ($urandom_range(0, 1) != 0) ? 12'h7C2 : 12'h7C0;
         else            a = bad_addrs[$urandom_range(0, 5)];
         wd = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) wd = wd & ~64'h8080_8080_8080_8080;
         if ($urandom_range(0, 4) == 0) wd[7:0] = 8'h0A;
         do_req($urandom_range(0, 3) != 0, a, wd, rd, err, upd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
